// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: 16-deep circular FIFO between the UART receiver and the UARTrd/UARTstat path.
// Read data is registered (1-cycle latency); writes to a full FIFO are dropped and flagged unless a read frees a slot that cycle.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 5,
    parameter int AF_LEVEL  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrTick,
    input  logic [DATA_BITS-1:0] wrData,
    input  logic                 rdReq,
    input  logic                 clrOverrun,
    output logic [DATA_BITS-1:0] rdData,
    output logic                 rdValid,
    output logic                 empty,
    output logic                 full,
    output logic                 almostFull,
    output logic                 overrun,
    output logic [CNT_W-1:0]     count,
    output logic [7:0]           status
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wrPtr;
    logic [ADDR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]     countReg;
    logic                 overrunReg;

    logic rdAccept;
    logic wrAccept;
    logic dropByte;

    // Flags come only from registered state, so rdReq never reaches an output combinationally.
    assign empty      = (countReg == '0);
    assign full       = (countReg == DEPTH_CNT);
    assign almostFull = (countReg >= AF_CNT);
    assign overrun    = overrunReg;
    assign count      = countReg;
    assign status     = {4'b0000, almostFull, overrunReg, full, empty};

    // A read in the same cycle frees the slot the incoming byte needs when full.
    assign rdAccept = rdReq && !empty;
    assign wrAccept = wrTick && (!full || rdAccept);
    assign dropByte = wrTick && full && !rdAccept;

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
        end else if (wrAccept) begin
            wrPtr <= wrPtr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr   <= '0;
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdAccept;
            if (rdAccept) begin
                rdData <= mem[rdPtr];
                rdPtr  <= rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countReg <= '0;
        end else begin
            case ({wrAccept, rdAccept})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrunReg <= 1'b0;
        end else if (dropByte) begin
            overrunReg <= 1'b1;
        end else if (clrOverrun) begin
            overrunReg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based reference.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wrTick;
    logic [7:0] wrData;
    logic       rdReq;
    logic       clrOverrun;
    logic [7:0] rdData;
    logic       rdValid;
    logic       empty;
    logic       full;
    logic       almostFull;
    logic       overrun;
    logic [4:0] count;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;

    // Reference state: byte queue, sticky flag, and last delivered byte.
    logic [7:0] q[$];
    logic       mOvr;
    logic [7:0] mData;
    logic       mValid;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .wrTick(wrTick), .wrData(wrData),
        .rdReq(rdReq), .clrOverrun(clrOverrun), .rdData(rdData),
        .rdValid(rdValid), .empty(empty), .full(full), .almostFull(almostFull),
        .overrun(overrun), .count(count), .status(status)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mStatus();
        return {4'b0000, q.size() >= 12, mOvr, q.size() == 16, q.size() == 0};
    endfunction

    function automatic void modelReset();
        q.delete();
        mOvr   = 1'b0;
        mData  = 8'h00;
        mValid = 1'b0;
    endfunction

    // Drive one clock of stimulus, advance the reference, and return #1 after the edge.
    task automatic cycle(input logic wt, input logic [7:0] wd, input logic rq, input logic clr);
        bit rdAcc;
        bit wrAcc;
        wrTick     = wt;
        wrData     = wd;
        rdReq      = rq;
        clrOverrun = clr;
        rdAcc  = rq && (q.size() > 0);
        wrAcc  = wt && ((q.size() < 16) || rdAcc);
        mValid = rdAcc;
        if (rdAcc) mData = q.pop_front();
        if (wrAcc) q.push_back(wd);
        if (wt && !wrAcc) mOvr = 1'b1;
        else if (clr)     mOvr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wrTick = 0; wrData = 0; rdReq = 0; clrOverrun = 0;
        reset = 1'b1;
        modelReset();
        #3;
        checks++;
        if (status !== 8'h01 || count !== 5'd0 || rdValid !== 1'b0 || rdData !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: status=%h count=%0d rdValid=%b rdData=%h, required 01/0/0/00",
                     status, count, rdValid, rdData);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdValid !== 1'b0 || rdData !== 8'h00 || status !== 8'h01) begin
                errors++;
                $display("FAIL empty_read: rdValid=%b rdData=%h status=%h, required 0/00/01",
                         rdValid, rdData, status);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp[2];
        exp[0] = 8'hA5;
        exp[1] = 8'h3C;
        cycle(1'b1, exp[0], 1'b0, 1'b0);
        cycle(1'b1, exp[1], 1'b0, 1'b0);
        checks++;
        if (count !== 5'd2) begin
            errors++;
            $display("FAIL basic_count: count=%0d required 2", count);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdValid !== 1'b1 || rdData !== exp[i]) begin
                errors++;
                $display("FAIL basic_read%0d: rdValid=%b rdData=%h, required 1/%h", i, rdValid, rdData, exp[i]);
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (rdValid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || rdData !== 8'h3C) begin
            errors++;
            $display("FAIL basic_after: rdValid=%b count=%0d empty=%b rdData=%h, required 0/0/1/3c",
                     rdValid, count, empty, rdData);
        end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (almostFull !== (i >= 11) || count !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_af%0d: almostFull=%b count=%0d, required %b/%0d",
                         i, almostFull, count, i >= 11, i + 1);
            end
        end
        checks++;
        if (status !== 8'h0A || full !== 1'b1) begin
            errors++;
            $display("FAIL full_status: status=%h full=%b, required 0a/1", status, full);
        end
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (status !== 8'h0E || count !== 5'd16 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_status: status=%h count=%0d overrun=%b, required 0e/16/1",
                     status, count, overrun);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdValid !== 1'b1 || rdData !== 8'(i)) begin
                errors++;
                $display("FAIL drain%0d: rdValid=%b rdData=%h, required 1/%h", i, rdValid, rdData, 8'(i));
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (rdValid !== 1'b0 || status !== 8'h01) begin
            errors++;
            $display("FAIL drain_end: rdValid=%b status=%h, required 0/01", rdValid, status);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] first;
        first = 8'h00;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            if (i == 0) first = d;
            cycle(1'b1, d, 1'b0, 1'b0);
        end
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd16 || overrun !== 1'b0 || rdValid !== 1'b1 || rdData !== first) begin
            errors++;
            $display("FAIL simul_full: count=%0d overrun=%b rdValid=%b rdData=%h, required 16/0/1/%h",
                     count, overrun, rdValid, rdData, first);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdValid !== 1'b1 || rdData !== mData) begin
                errors++;
                $display("FAIL simul_drain%0d: rdValid=%b rdData=%h, required 1/%h", i, rdValid, rdData, mData);
            end
        end
        checks++;
        if (rdData !== 8'h55 || empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_last: rdData=%h empty=%b, required 55/1", rdData, empty);
        end
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL clr_vs_set: overrun=%b count=%0d, required 1/16", overrun, count);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b0 || status !== 8'h0A) begin
            errors++;
            $display("FAIL clr_alone: overrun=%b status=%h, required 0/0a", overrun, status);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdData !== mData || rdData === 8'hEE || rdData === 8'hEF && mData !== 8'hEF) begin
                errors++;
                $display("FAIL clr_drain%0d: rdData=%h, required %h", i, rdData, mData);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (rdValid !== 1'b1 || rdData !== 8'(8'h10 + i) || count !== 5'd0) begin
                errors++;
                $display("FAIL wrap%0d: rdValid=%b rdData=%h count=%0d, required 1/%h/0",
                         i, rdValid, rdData, count, 8'(8'h10 + i));
            end
        end
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        wrTick = 0; rdReq = 0;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checks++;
        if (status !== 8'h01 || count !== 5'd0 || rdValid !== 1'b0 || rdData !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: status=%h count=%0d rdValid=%b rdData=%h overrun=%b, required 01/0/0/00/0",
                     status, count, rdValid, rdData, overrun);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 58), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4));
            checks++;
            if (rdValid !== mValid || rdData !== mData || count !== 5'(q.size()) || status !== mStatus()) begin
                errors++;
                $display("FAIL random%0d: rdValid=%b rdData=%h count=%0d status=%h, required %b/%h/%0d/%h",
                         i, rdValid, rdData, count, status, mValid, mData, q.size(), mStatus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overrun();
        test_simul_full();
        test_overrun_clear();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
